// File: rtl/mvc_pkg.sv
// Shared definitions for the multi-channel value controller: tick encoding
// and a constant-evaluable ceil(log2) used to size counters and selectors.
package mvc_pkg;

    typedef enum logic [1:0] {
        TICK_NONE   = 2'd0,
        TICK_PRESS  = 2'd1,
        TICK_REPEAT = 2'd2
    } tick_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/btn_conditioner.sv
// One push button (active-low): 2-flop synchroniser, stability debouncer and
// optional hold/auto-repeat timer, producing registered PRESS/REPEAT ticks.
module btn_conditioner
    import mvc_pkg::*;
#(
    parameter int DEB_CYC   = 50000,
    parameter int HOLD_CYC  = 25000000,
    parameter int REP_CYC   = 5000000,
    parameter bit REPEAT_EN = 1'b1
) (
    input  logic  i_CLK,
    input  logic  i_RST,
    input  logic  i_btn_n,
    output tick_t o_tick
);

    localparam int DW = clog2(DEB_CYC + 1);
    localparam int TW = clog2(((HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC) + 1);

    logic [1:0]    sync;
    logic          deb;
    logic [DW-1:0] deb_cnt;
    logic          armed;
    logic [DW-1:0] arm_cnt;
    logic [TW-1:0] tmr;
    logic          rep_phase;

    logic deb_accept;
    logic arm_done;
    logic held;
    logic tmr_hit;

    assign deb_accept = (sync[1] != deb) && (deb_cnt == DW'(DEB_CYC - 1));
    assign arm_done   = sync[1] && (arm_cnt == DW'(DEB_CYC - 1));
    assign held       = armed && !deb && !deb_accept;
    assign tmr_hit    = rep_phase ? (tmr == TW'(REP_CYC - 1)) : (tmr == TW'(HOLD_CYC - 1));

    // The synchroniser resets to "pressed" so a button held through reset
    // cannot arm the block; it arms only after a full debounced release.
    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            sync      <= 2'b00;
            deb       <= 1'b1;
            deb_cnt   <= '0;
            armed     <= 1'b0;
            arm_cnt   <= '0;
            tmr       <= '0;
            rep_phase <= 1'b0;
            o_tick    <= TICK_NONE;
        end else begin
            // NOTE: clocked state uses non-blocking assignments so every
            // right-hand side sees pre-edge values regardless of statement order.
            sync   <= {sync[0], i_btn_n};
            o_tick <= TICK_NONE;

            if (deb_accept) begin
                deb     <= sync[1];
                deb_cnt <= '0;
            end else if (sync[1] != deb) begin
                deb_cnt <= deb_cnt + DW'(1);
            end else begin
                deb_cnt <= '0;
            end

            if (!armed) begin
                if (arm_done)     armed   <= 1'b1;
                else if (sync[1]) arm_cnt <= arm_cnt + DW'(1);
                else              arm_cnt <= '0;
            end

            if (armed && deb_accept && !sync[1]) o_tick <= TICK_PRESS;

            if (REPEAT_EN && held) begin
                if (tmr_hit) begin
                    o_tick    <= TICK_REPEAT;
                    tmr       <= '0;
                    rep_phase <= 1'b1;
                end else begin
                    tmr <= tmr + TW'(1);
                end
            end else begin
                tmr       <= '0;
                rep_phase <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/multi_value_control.sv
// Button-driven bank of N_CH bounded values: inc/dec with auto-repeat on the
// selected channel, channel-select button, saturate or wrap at the limits.
module multi_value_control
    import mvc_pkg::*;
#(
    parameter int N_CH      = 4,
    parameter int N_BIT     = 8,
    parameter int VAL_MIN   = 0,
    parameter int VAL_MAX   = 255,
    parameter int VAL_RST   = 0,
    parameter int STEP      = 1,
    parameter int FAST_STEP = 10,
    parameter int WRAP      = 0,
    parameter int DEB_CYC   = 50000,
    parameter int HOLD_CYC  = 25000000,
    parameter int REP_CYC   = 5000000,
    localparam int CH_W     = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic                  i_CLK,
    input  logic                  i_RST,
    input  logic                  i_inc_btn,
    input  logic                  i_dec_btn,
    input  logic                  i_ch_btn,
    output logic [CH_W-1:0]       o_ch_sel,
    output logic [N_BIT-1:0]      o_count_sel,
    output logic [N_CH*N_BIT-1:0] o_count_all,
    output logic                  o_change
);

    localparam int AW = N_BIT + 2;
    localparam logic signed [AW-1:0] MIN_S = AW'(VAL_MIN);
    localparam logic signed [AW-1:0] MAX_S = AW'(VAL_MAX);

    tick_t inc_tick, dec_tick, ch_tick;

    btn_conditioner #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(1'b1))
        u_inc (.i_CLK(i_CLK), .i_RST(i_RST), .i_btn_n(i_inc_btn), .o_tick(inc_tick));
    btn_conditioner #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(1'b1))
        u_dec (.i_CLK(i_CLK), .i_RST(i_RST), .i_btn_n(i_dec_btn), .o_tick(dec_tick));
    btn_conditioner #(.DEB_CYC(DEB_CYC), .HOLD_CYC(HOLD_CYC), .REP_CYC(REP_CYC), .REPEAT_EN(1'b0))
        u_ch  (.i_CLK(i_CLK), .i_RST(i_RST), .i_btn_n(i_ch_btn),  .o_tick(ch_tick));

    function automatic logic signed [AW-1:0] step_of(input tick_t t);
        case (t)
            TICK_PRESS:  return AW'(STEP);
            TICK_REPEAT: return AW'(FAST_STEP);
            default:     return '0;
        endcase
    endfunction

    logic [N_BIT-1:0]       vals [N_CH];
    logic signed [AW-1:0]   cur_s, sum_s;
    logic [N_BIT-1:0]       nxt_val;
    logic [CH_W-1:0]        ch_nxt;

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        cur_s   = $signed({2'b00, vals[o_ch_sel]});
        sum_s   = cur_s;
        nxt_val = vals[o_ch_sel];
        ch_nxt  = o_ch_sel;

        // Simultaneous inc and dec ticks cancel by taking neither branch.
        if (inc_tick != TICK_NONE && dec_tick == TICK_NONE)
            sum_s = cur_s + step_of(inc_tick);
        else if (dec_tick != TICK_NONE && inc_tick == TICK_NONE)
            sum_s = cur_s - step_of(dec_tick);

        if (sum_s > MAX_S)      nxt_val = (WRAP != 0) ? N_BIT'(VAL_MIN) : N_BIT'(VAL_MAX);
        else if (sum_s < MIN_S) nxt_val = (WRAP != 0) ? N_BIT'(VAL_MAX) : N_BIT'(VAL_MIN);
        else                    nxt_val = sum_s[N_BIT-1:0];

        if (ch_tick != TICK_NONE)
            ch_nxt = (o_ch_sel == CH_W'(N_CH - 1)) ? '0 : o_ch_sel + CH_W'(1);
    end

    always_ff @(posedge i_CLK or posedge i_RST) begin
        if (i_RST) begin
            // NOTE: the value bank is a handful of flops, not a RAM macro, so
            // it is reset element by element like any other state.
            for (int k = 0; k < N_CH; k++) vals[k] <= N_BIT'(VAL_RST);
            o_ch_sel <= '0;
            o_change <= 1'b0;
        end else begin
            vals[o_ch_sel] <= nxt_val;
            o_change       <= (nxt_val != vals[o_ch_sel]);
            o_ch_sel       <= ch_nxt;
        end
    end

    assign o_count_sel = vals[o_ch_sel];

    for (genvar k = 0; k < N_CH; k++) begin : g_all
        assign o_count_all[k*N_BIT +: N_BIT] = vals[k];
    end

endmodule

// File: tb/tb_multi_value_control.sv
// Scoreboard bench: stimulus queues expected o_change events (cycle, channel,
// full value bank); a negedge monitor pops and compares when o_change fires.
module tb_multi_value_control;

    typedef struct {
        int          at;
        logic [1:0]  ch;
        logic [31:0] all;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  b0  = 3'b111;   // [0]=inc [1]=dec [2]=ch, saturating DUT
    logic [2:0]  b1  = 3'b111;   // same for wrapping DUT
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    logic [1:0]  sel0, sel1;
    logic [7:0]  cs0, cs1;
    logic [31:0] all0, all1;
    logic        chg0, chg1;

    exp_t        q0[$];
    exp_t        q1[$];
    logic [1:0]  chq[$];
    exp_t        me0, me1;
    logic [1:0]  prev_sel0 = 2'd0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    multi_value_control #(
        .N_CH(4), .N_BIT(8), .VAL_MIN(0), .VAL_MAX(20), .VAL_RST(5), .STEP(1), .FAST_STEP(4),
        .WRAP(0), .DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(5)
    ) dut (
        .i_CLK(clk), .i_RST(rst), .i_inc_btn(b0[0]), .i_dec_btn(b0[1]), .i_ch_btn(b0[2]),
        .o_ch_sel(sel0), .o_count_sel(cs0), .o_count_all(all0), .o_change(chg0)
    );

    multi_value_control #(
        .N_CH(4), .N_BIT(8), .VAL_MIN(0), .VAL_MAX(20), .VAL_RST(5), .STEP(1), .FAST_STEP(4),
        .WRAP(1), .DEB_CYC(4), .HOLD_CYC(20), .REP_CYC(5)
    ) dut_w (
        .i_CLK(clk), .i_RST(rst), .i_inc_btn(b1[0]), .i_dec_btn(b1[1]), .i_ch_btn(b1[2]),
        .o_ch_sel(sel1), .o_count_sel(cs1), .o_count_all(all1), .o_change(chg1)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every o_change pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (chg0) begin
                if (q0.size() == 0) check("spurious_change_sat", 32'(chg0), 32'd0);
                else begin
                    me0 = q0.pop_front();
                    check("change_cycle_sat", cyc, me0.at);
                    check("count_all_sat", all0, me0.all);
                    check("ch_sel_sat", 32'(sel0), 32'(me0.ch));
                    check("count_sel_sat", 32'(cs0), (me0.all >> (me0.ch * 8)) & 32'hFF);
                end
            end
            if (chg1) begin
                if (q1.size() == 0) check("spurious_change_wrap", 32'(chg1), 32'd0);
                else begin
                    me1 = q1.pop_front();
                    check("change_cycle_wrap", cyc, me1.at);
                    check("count_all_wrap", all1, me1.all);
                    check("ch_sel_wrap", 32'(sel1), 32'(me1.ch));
                    check("count_sel_wrap", 32'(cs1), (me1.all >> (me1.ch * 8)) & 32'hFF);
                end
            end
            if (sel0 != prev_sel0) begin
                if (chq.size() == 0) check("spurious_sel_step", 32'(sel0), 32'(prev_sel0));
                else                 check("ch_sel_sequence", 32'(sel0), 32'(chq.pop_front()));
            end
        end
        prev_sel0 <= sel0;
    end

    task automatic push(input int d, input int at, input logic [1:0] ch, input logic [31:0] all);
        exp_t e;
        e.at  = at;
        e.ch  = ch;
        e.all = all;
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endtask

    task automatic set_btn(input int d, input int b, input logic lvl);
        if (d == 0) b0[b] = lvl;
        else        b1[b] = lvl;
    endtask

    // Press button b of DUT d; a change, if expected, appears 7 cycles later.
    task automatic press(input int d, input int b, input int low_n, input int high_n,
                         input bit exp_chg, input logic [31:0] exp_all, input logic [1:0] exp_ch);
        @(negedge clk);
        if (exp_chg) push(d, cyc + 7, exp_ch, exp_all);
        set_btn(d, b, 1'b0);
        repeat (low_n) @(negedge clk);
        set_btn(d, b, 1'b1);
        repeat (high_n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        repeat (3) @(negedge clk);
        check("reset_all_sat", all0, 32'h05050505);
        check("reset_sel_sat", 32'(sel0), 32'd0);
        check("reset_change_sat", 32'(chg0), 32'd0);
        check("reset_all_wrap", all1, 32'h05050505);
        rst = 1'b0;
        repeat (10) @(negedge clk);

        // 3-cycle glitch never reaches the debounce threshold
        press(0, 0, 3, 15, 1'b0, 32'h0, 2'd0);
        check("glitch_no_change", all0, 32'h05050505);

        // single 10-cycle press: 5 -> 6 on ch0
        press(0, 0, 10, 15, 1'b1, 32'h05050506, 2'd0);

        // hold 60 cycles from 5: 6, then repeats of +4, clamped at 20
        do_reset();
        @(negedge clk);
        c0 = cyc;
        push(0, c0 + 7,  2'd0, 32'h05050506);
        push(0, c0 + 27, 2'd0, 32'h0505050A);
        push(0, c0 + 32, 2'd0, 32'h0505050E);
        push(0, c0 + 37, 2'd0, 32'h05050512);
        push(0, c0 + 42, 2'd0, 32'h05050514);
        b0[0] = 1'b0;
        repeat (60) @(negedge clk);
        b0[0] = 1'b1;
        repeat (20) @(negedge clk);
        check("hold_final_clamped", all0, 32'h05050514);

        // five channel presses: 1,2,3,0,1
        for (int k = 1; k <= 5; k++) begin
            chq.push_back(2'(k % 4));
            press(0, 2, 8, 10, 1'b0, 32'h0, 2'd0);
        end
        check("ch_sel_after_five", 32'(sel0), 32'd1);

        // inc on ch1 touches only bits [15:8]
        press(0, 0, 10, 15, 1'b1, 32'h05050614, 2'd1);

        // simultaneous inc and dec cancel
        @(negedge clk);
        b0[1:0] = 2'b00;
        repeat (10) @(negedge clk);
        b0[1:0] = 2'b11;
        repeat (20) @(negedge clk);
        check("simul_no_change", all0, 32'h05050614);

        // reset mid-repeat with inc held through deassertion
        @(negedge clk);
        c0 = cyc;
        push(0, c0 + 7,  2'd1, 32'h05050714);
        push(0, c0 + 27, 2'd1, 32'h05050B14);
        b0[0] = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("midrep_reset_all", all0, 32'h05050505);
        check("midrep_reset_sel", 32'(sel0), 32'd0);
        check("midrep_reset_change", 32'(chg0), 32'd0);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("held_through_reset", all0, 32'h05050505);
        b0[0] = 1'b1;
        repeat (15) @(negedge clk);
        press(0, 0, 10, 15, 1'b1, 32'h05050506, 2'd0);

        // wrapping DUT: select ch1, walk 5 down to 0, wrap to 20, wrap back to 0
        press(1, 2, 10, 15, 1'b0, 32'h0, 2'd0);
        check("wrap_sel_ch1", 32'(sel1), 32'd1);
        for (int v = 4; v >= 0; v--)
            press(1, 1, 10, 12, 1'b1, 32'h05050005 | (32'(v) << 8), 2'd1);
        press(1, 1, 10, 12, 1'b1, 32'h05051405, 2'd1);
        press(1, 0, 10, 12, 1'b1, 32'h05050005, 2'd1);

        repeat (10) @(negedge clk);
        check("sat_queue_drained", 32'(q0.size()), 32'd0);
        check("wrap_queue_drained", 32'(q1.size()), 32'd0);
        check("sel_queue_drained", 32'(chq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multi_value_control.md
MULTI_VALUE_CONTROL -- requirements
Module: multi_value_control

Interface
REQ-001 SHALL have parameter N_CH, default 4, meaning number of independent value channels (1..16).
REQ-002 SHALL have parameter N_BIT, default 8, meaning width of each channel value.
REQ-003 SHALL have parameters VAL_MIN 0, VAL_MAX 255, VAL_RST 0, meaning channel range and reset value, with VAL_MIN <= VAL_RST <= VAL_MAX < 2^N_BIT.
REQ-004 SHALL have parameter STEP, default 1, meaning single-press increment.
REQ-005 SHALL have parameter FAST_STEP, default 10, meaning increment per auto-repeat tick.
REQ-006 SHALL have parameter WRAP, default 0, meaning 0 = saturate at limits, 1 = wrap around.
REQ-007 SHALL have parameters DEB_CYC 50000, HOLD_CYC 25000000, REP_CYC 5000000, meaning debounce, hold-before-repeat and repeat-period lengths in clock cycles.
REQ-008 SHALL have port i_CLK, input, 1, meaning the single clock; all logic on its rising edge.
REQ-009 SHALL have port i_RST, input, 1, meaning asynchronous, active-high reset.
REQ-010 SHALL have ports i_inc_btn, i_dec_btn and i_ch_btn, input, 1 each, meaning asynchronous active-low (pressed = 0) buttons.
REQ-011 SHALL have port o_ch_sel, output, CH_W = max(1,clog2(N_CH)), meaning the selected channel.
REQ-012 SHALL have port o_count_sel, output, N_BIT, meaning the selected channel's value.
REQ-013 SHALL have port o_count_all, output, N_CH*N_BIT, meaning all values, channel k at bits [k*N_BIT +: N_BIT].
REQ-014 SHALL have port o_change, output, 1, meaning a one-cycle pulse when any stored value changes.

Function
REQ-015 Each button SHALL pass through a 2-flop synchroniser, then a debouncer that accepts a new level only after DEB_CYC consecutive identical synchronised samples.
REQ-016 A debounced 1->0 transition SHALL generate one press tick; the value SHALL update on the next clock edge, giving 2+DEB_CYC+1 cycles from the button edge to the output.
REQ-017 For inc/dec, if debounced-low persists HOLD_CYC cycles after the press tick, a repeat tick SHALL fire, then every REP_CYC cycles until release; i_ch_btn SHALL NOT auto-repeat.
REQ-018 A press tick SHALL apply STEP and a repeat tick SHALL apply FAST_STEP, to the selected channel only.
REQ-019 Arithmetic SHALL use N_BIT+2 signed-safe width so no intermediate overflow or underflow occurs.
REQ-020 WRAP=0: results above VAL_MAX SHALL clamp to VAL_MAX and results below VAL_MIN SHALL clamp to VAL_MIN.
REQ-021 WRAP=1: incrementing past VAL_MAX SHALL yield VAL_MIN, and decrementing below VAL_MIN SHALL yield VAL_MAX; step remainders are discarded.
REQ-022 Inc and dec ticks in the same cycle SHALL cancel, leaving the value unchanged and o_change low.
REQ-023 A ch_btn tick SHALL advance o_ch_sel modulo N_CH; an inc/dec tick in the same cycle SHALL apply to the old channel.
REQ-024 o_change SHALL pulse high for one cycle only when the new value differs from the old value, so saturated presses give no pulse.
REQ-025 Releasing a button SHALL cancel the hold/repeat timers immediately; re-press restarts from zero.

Reset
REQ-026 While i_RST is high, all channels SHALL be VAL_RST, o_ch_sel 0, o_change 0, timers 0, and debounced levels 1 (released).
REQ-027 Reset asserted mid-press or mid-repeat SHALL abort the operation; a button held through deassertion SHALL NOT generate a tick until released and re-pressed.

Structure
REQ-028 Package mvc_pkg SHALL hold the clog2 function and the tick-type encoding (NONE, PRESS, REPEAT).
REQ-029 Sub-module btn_conditioner SHALL contain the synchroniser, debouncer and hold/repeat timer with a REPEAT_EN parameter; it SHALL be instantiated three times.
REQ-030 Channel values SHALL be a register array with a single update path indexed by o_ch_sel.

Verification (N_CH=4, N_BIT=8, MIN=0, MAX=20, RST=5, STEP=1, FAST_STEP=4, DEB_CYC=4, HOLD_CYC=20, REP_CYC=5)
REQ-031 Single inc press of 10 cycles -> ch0 goes 5->6 exactly 7 cycles after the edge, with one o_change pulse; a 3-cycle glitch causes no change.
REQ-032 Inc held 60 cycles on ch0 from 5 -> 6, then 10, 14, 18, 20 (clamped), with no o_change on the further clamped ticks.
REQ-033 WRAP=1, ch1 at 0, one dec press -> 20; at 20, one inc press -> 0.
REQ-034 ch_btn pressed 5 times -> o_ch_sel sequence 1,2,3,0,1; inc on ch1 changes only bits [15:8] of o_count_all.
REQ-035 Simultaneous inc and dec debounced edges -> no value change and no o_change.
REQ-036 i_RST asserted during a repeat with inc held through deassertion -> all channels 5, no tick until the button is released and re-pressed.
